// File: rtl/rv32_timer_pkg.sv
// Shared definitions for the rv32_timer machine timer: register word offsets,
// bus FSM states, reset constants and the byte-merge helper.
package rv32_timer_pkg;

    // Word offsets decoded from address_in[4:2]
    localparam logic [2:0] RV32_TIMER_MTIME_LO    = 3'd0;
    localparam logic [2:0] RV32_TIMER_MTIME_HI    = 3'd1;
    localparam logic [2:0] RV32_TIMER_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] RV32_TIMER_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] RV32_TIMER_MSIP        = 3'd4;

    // mtimecmp starts at the maximum so no timer interrupt is pending out of reset
    localparam logic [63:0] RV32_TIMER_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE,
        ACK
    } rv32_timer_state_e;

    // Replace only the bytes of old_value whose mask bit is set
    function automatic logic [31:0] rv32_timer_merge(input logic [31:0] old_value,
                                                     input logic [31:0] new_value,
                                                     input logic [3:0]  mask);
        logic [31:0] result;
        result = old_value;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_value[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rv32_timer_if.sv
// Data-memory bus slice seen by the rv32_timer: request, byte-masked write data,
// registered read data and a one-cycle ready acknowledge.
interface rv32_timer_if;

    logic        sel_in;
    logic [31:0] address_in;
    logic        read_in;
    logic        write_in;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic [31:0] read_value_out;
    logic        ready_out;

    modport master (
        output sel_in,
        output address_in,
        output read_in,
        output write_in,
        output write_mask_in,
        output write_value_in,
        input  read_value_out,
        input  ready_out
    );

    modport slave (
        input  sel_in,
        input  address_in,
        input  read_in,
        input  write_in,
        input  write_mask_in,
        input  write_value_in,
        output read_value_out,
        output ready_out
    );

endinterface

// File: rtl/rv32_timer_prescaler.sv
// Divides clk down to the mtime increment rate: tick_out is high for one cycle
// out of every PRESCALE_DIV. With PRESCALE_DIV = 1 the tick is constant.
module rv32_timer_prescaler #(
    parameter int unsigned PRESCALE_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick_out
);

    if (PRESCALE_DIV < 1) begin : g_bad_div
        $error("rv32_timer_prescaler: PRESCALE_DIV must be at least 1");
        assign tick_out = 1'b0;
    end else if (PRESCALE_DIV == 1) begin : g_every_cycle
        assign tick_out = 1'b1;
        // No counter needed, so clock and reset go unused here
        logic unused_clk_reset;
        assign unused_clk_reset = clk ^ reset;
    end else begin : g_counter
        localparam int unsigned CountWidth = $clog2(PRESCALE_DIV);
        localparam logic [CountWidth-1:0] CountMax = CountWidth'(PRESCALE_DIV - 1);

        logic [CountWidth-1:0] count_q;

        // Free-running 0..PRESCALE_DIV-1 counter, independent of bus traffic
        always_ff @(posedge clk) begin
            if (reset) begin
                count_q <= '0;
            end else if (count_q == CountMax) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + CountWidth'(1);
            end
        end

        assign tick_out = (count_q == CountMax);
    end

endmodule

// File: rtl/rv32_timer.sv
// Memory-mapped RV32 machine timer: mtime/mtimecmp behind a single-cycle-ack bus
// slave, driving MTIP (and optionally MSIP) into the CSR file and exporting mtime
// for TIME/TIMEH reads.
// Optional feature: define RV32_TIMER_MSIP_EN to implement the MSIP register at
// word offset 4; otherwise that offset is reserved and software_interrupt_out is 0.
module rv32_timer
    import rv32_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    rv32_timer_if.slave       bus,
    output logic [63:0]       time_out,
    output logic              timer_interrupt_out,
    output logic              software_interrupt_out
);

    logic              tick;
    rv32_timer_state_e state_q;
    logic              ready_q;
    logic [31:0]       read_value_q;
    logic [31:0]       read_data;
    logic [2:0]        offset;
    logic              req;
    logic              wr_en;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic              timer_irq_q;

    rv32_timer_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .tick_out(tick)
    );

    assign offset = bus.address_in[4:2];
    // Requests are only sampled in IDLE; a request held through ACK waits a cycle
    assign req    = (state_q == IDLE) && bus.sel_in && (bus.read_in || bus.write_in);
    assign wr_en  = req && bus.write_in;

    // Byte-lane and upper address bits carry no meaning for this word-only slave
    logic unused_address;
    assign unused_address = ^{bus.address_in[31:5], bus.address_in[1:0]};

`ifdef RV32_TIMER_MSIP_EN
    logic msip_q;

    // Software interrupt pending bit, written through byte lane 0
    always_ff @(posedge clk) begin
        if (reset) begin
            msip_q <= 1'b0;
        end else if (wr_en && (offset == RV32_TIMER_MSIP) && bus.write_mask_in[0]) begin
            msip_q <= bus.write_value_in[0];
        end
    end

    assign software_interrupt_out = msip_q;
`else
    assign software_interrupt_out = 1'b0;
`endif

    // Read mux over current (pre-write) register values; reserved offsets read 0
    always_comb begin
        read_data = '0;
        case (offset)
            RV32_TIMER_MTIME_LO:    read_data = mtime_q[31:0];
            RV32_TIMER_MTIME_HI:    read_data = mtime_q[63:32];
            RV32_TIMER_MTIMECMP_LO: read_data = mtimecmp_q[31:0];
            RV32_TIMER_MTIMECMP_HI: read_data = mtimecmp_q[63:32];
`ifdef RV32_TIMER_MSIP_EN
            RV32_TIMER_MSIP:        read_data = {31'b0, msip_q};
`endif
            default:                read_data = '0;
        endcase
    end

    // mtime next state: a bus write to either half suppresses that cycle's increment
    always_comb begin
        mtime_d = mtime_q;
        if (wr_en && (offset == RV32_TIMER_MTIME_LO)) begin
            mtime_d[31:0] = rv32_timer_merge(mtime_q[31:0], bus.write_value_in,
                                             bus.write_mask_in);
        end else if (wr_en && (offset == RV32_TIMER_MTIME_HI)) begin
            mtime_d[63:32] = rv32_timer_merge(mtime_q[63:32], bus.write_value_in,
                                              bus.write_mask_in);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // mtimecmp next state: changes only by bus writes
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_en && (offset == RV32_TIMER_MTIMECMP_LO)) begin
            mtimecmp_d[31:0] = rv32_timer_merge(mtimecmp_q[31:0], bus.write_value_in,
                                                bus.write_mask_in);
        end else if (wr_en && (offset == RV32_TIMER_MTIMECMP_HI)) begin
            mtimecmp_d[63:32] = rv32_timer_merge(mtimecmp_q[63:32], bus.write_value_in,
                                                 bus.write_mask_in);
        end
    end

    // Timer state and the registered compare feeding MTIP
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q     <= '0;
            mtimecmp_q  <= RV32_TIMER_MTIMECMP_RESET;
            timer_irq_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            timer_irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    // Bus FSM: IDLE accepts a request, ACK presents ready for exactly one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            read_value_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q      <= ACK;
                        ready_q      <= 1'b1;
                        read_value_q <= read_data;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_out        = ready_q;
    assign bus.read_value_out   = read_value_q;
    assign time_out             = mtime_q;
    assign timer_interrupt_out  = timer_irq_q;

endmodule

// File: tb/tb_rv32_timer.sv
// Self-checking bench for rv32_timer: directed scenarios plus randomized bus
// traffic compared against a transaction-level model of the timer.
module tb_rv32_timer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset4 = 1'b1;
    always #5 clk = ~clk;

    rv32_timer_if bus ();
    rv32_timer_if bus4 ();

    logic [63:0] time_out, time4;
    logic        irq, irq4, sirq, sirq4;

    rv32_timer #(.PRESCALE_DIV(1)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .bus                   (bus),
        .time_out              (time_out),
        .timer_interrupt_out   (irq),
        .software_interrupt_out(sirq)
    );

    rv32_timer #(.PRESCALE_DIV(4)) dut4 (
        .clk                   (clk),
        .reset                 (reset4),
        .bus                   (bus4),
        .time_out              (time4),
        .timer_interrupt_out   (irq4),
        .software_interrupt_out(sirq4)
    );

`ifdef RV32_TIMER_MSIP_EN
    localparam bit MSIP_EN = 1'b1;
`else
    localparam bit MSIP_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (PRESCALE_DIV = 1 instance) ----------------
    logic [63:0] m_time, m_cmp;
    logic        m_irq, m_msip, m_ack;
    logic [31:0] m_rd;
    logic        m_req, m_wr;
    logic [2:0]  m_off;

    assign m_off = bus.address_in[4:2];
    assign m_req = bus.sel_in && (bus.read_in || bus.write_in) && !m_ack;
    assign m_wr  = m_req && bus.write_in;

    function automatic logic [31:0] mask_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] m);
        logic [31:0] byte_en;
        byte_en = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (new_v & byte_en) | (old_v & ~byte_en);
    endfunction

    function automatic logic [63:0] model_time(input logic [63:0] t, input logic wr,
                                               input logic [2:0] off, input logic [3:0] m,
                                               input logic [31:0] d);
        if (wr && off == 3'd0) return {t[63:32], mask_merge(t[31:0], d, m)};
        if (wr && off == 3'd1) return {mask_merge(t[63:32], d, m), t[31:0]};
        return t + 64'd1;
    endfunction

    function automatic logic [63:0] model_cmp(input logic [63:0] c, input logic wr,
                                              input logic [2:0] off, input logic [3:0] m,
                                              input logic [31:0] d);
        if (wr && off == 3'd2) return {c[63:32], mask_merge(c[31:0], d, m)};
        if (wr && off == 3'd3) return {mask_merge(c[63:32], d, m), c[31:0]};
        return c;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] off, input logic [63:0] t,
                                               input logic [63:0] c, input logic s);
        case (off)
            3'd0: return t[31:0];
            3'd1: return t[63:32];
            3'd2: return c[31:0];
            3'd3: return c[63:32];
            3'd4: return MSIP_EN ? {31'b0, s} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_time <= 64'd0;
            m_cmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_irq  <= 1'b0;
            m_msip <= 1'b0;
            m_ack  <= 1'b0;
            m_rd   <= 32'd0;
        end else begin
            m_irq  <= (m_time >= m_cmp);
            m_ack  <= m_req;
            if (m_req) m_rd <= model_read(m_off, m_time, m_cmp, m_msip);
            m_time <= model_time(m_time, m_wr, m_off, bus.write_mask_in, bus.write_value_in);
            m_cmp  <= model_cmp(m_cmp, m_wr, m_off, bus.write_mask_in, bus.write_value_in);
            if (MSIP_EN && m_wr && m_off == 3'd4 && bus.write_mask_in[0])
                m_msip <= bus.write_value_in[0];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and advance to the ACK cycle
    task automatic bus_start(input bit rd, input bit wr, input logic [2:0] off,
                             input logic [3:0] m, input logic [31:0] d);
        logic [31:0] a;
        a = $urandom();
        a[4:2] = off;
        bus.sel_in = 1'b1;
        bus.read_in = rd;
        bus.write_in = wr;
        bus.address_in = a;
        bus.write_mask_in = m;
        bus.write_value_in = d;
        step();
    endtask

    // Drop the request and advance back to IDLE
    task automatic bus_end();
        bus.sel_in = 1'b0;
        bus.read_in = 1'b0;
        bus.write_in = 1'b0;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (time_out !== 64'd0) begin errors++;
            $display("FAIL reset_time got %h want 0", time_out); end
        checks++; if (bus.ready_out !== 1'b0 || bus.read_value_out !== 32'd0) begin errors++;
            $display("FAIL reset_bus got rdy=%b rd=%h want 0/0", bus.ready_out, bus.read_value_out); end
        checks++; if (irq !== 1'b0 || sirq !== 1'b0) begin errors++;
            $display("FAIL reset_irq got t=%b s=%b want 0/0", irq, sirq); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (bus.ready_out !== 1'b0) begin errors++;
                $display("FAIL idle_ready cyc %0d got %b want 0", i, bus.ready_out); end
        end
        checks++; if (time_out !== 64'd10) begin errors++;
            $display("FAIL idle_time got %0d want 10", time_out); end
        checks++; if (irq !== 1'b0) begin errors++;
            $display("FAIL idle_irq got %b want 0", irq); end
    endtask

    task automatic test_cmp_irq();
        int n;
        bus_start(1'b0, 1'b1, 3'd3, 4'hF, 32'd0);
        bus_end();
        bus_start(1'b0, 1'b1, 3'd2, 4'hF, 32'd20);
        bus_end();
        n = 0;
        while (time_out !== 64'd20 && n < 40) begin
            step();
            n++;
        end
        checks++; if (time_out !== 64'd20) begin errors++;
            $display("FAIL cmp_reach got %0d want 20 within 40 cycles", time_out); end
        checks++; if (irq !== 1'b0) begin errors++;
            $display("FAIL cmp_irq_eq got %b want 0", irq); end
        step();
        checks++; if (irq !== 1'b1) begin errors++;
            $display("FAIL cmp_irq_rise got %b want 1", irq); end
        bus_start(1'b0, 1'b1, 3'd2, 4'hF, 32'd100);
        checks++; if (irq !== 1'b1 || bus.ready_out !== 1'b1) begin errors++;
            $display("FAIL cmp_ack got irq=%b rdy=%b want 1/1", irq, bus.ready_out); end
        bus_end();
        checks++; if (irq !== 1'b0) begin errors++;
            $display("FAIL cmp_irq_clear got %b want 0", irq); end
    endtask

    task automatic test_wrap();
        bus_start(1'b0, 1'b1, 3'd1, 4'hF, 32'hFFFF_FFFF);
        bus_end();
        bus_start(1'b0, 1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF);
        checks++; if (time_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++;
            $display("FAIL wrap_ones got %h want all ones", time_out); end
        bus_end();
        checks++; if (time_out !== 64'd0) begin errors++;
            $display("FAIL wrap_zero got %h want 0", time_out); end
        bus_start(1'b0, 1'b1, 3'd0, 4'hF, 32'h0000_1234);
        checks++; if (time_out !== 64'h1234) begin errors++;
            $display("FAIL tick_write got %h want 1234", time_out); end
        bus_end();
        checks++; if (time_out !== 64'h1235) begin errors++;
            $display("FAIL tick_write_next got %h want 1235", time_out); end
        bus_start(1'b0, 1'b1, 3'd1, 4'b0010, 32'h1122_AB44);
        checks++; if (time_out !== 64'h0000_AB00_0000_1235) begin errors++;
            $display("FAIL hi_mask_write got %h want 0000ab0000001235", time_out); end
        bus_end();
        checks++; if (time_out !== m_time || irq !== m_irq) begin errors++;
            $display("FAIL wrap_model got %h/%b want %h/%b", time_out, irq, m_time, m_irq); end
    endtask

    task automatic test_byte_mask();
        bus_start(1'b0, 1'b1, 3'd2, 4'hF, 32'h1122_3344);
        bus_end();
        bus_start(1'b0, 1'b1, 3'd2, 4'b0101, 32'hAABB_CCDD);
        bus_end();
        bus_start(1'b1, 1'b0, 3'd2, 4'hF, 32'd0);
        checks++; if (bus.read_value_out !== 32'h11BB_33DD) begin errors++;
            $display("FAIL mask_read got %h want 11bb33dd", bus.read_value_out); end
        bus_end();
        bus_start(1'b1, 1'b1, 3'd2, 4'h0, 32'h5555_5555);
        checks++; if (bus.read_value_out !== 32'h11BB_33DD) begin errors++;
            $display("FAIL mask_none got %h want 11bb33dd", bus.read_value_out); end
        bus_end();
        bus_start(1'b1, 1'b1, 3'd2, 4'hF, 32'hCAFE_F00D);
        checks++; if (bus.read_value_out !== 32'h11BB_33DD) begin errors++;
            $display("FAIL rw_prewrite got %h want 11bb33dd", bus.read_value_out); end
        bus_end();
        bus_start(1'b1, 1'b0, 3'd2, 4'hF, 32'd0);
        checks++; if (bus.read_value_out !== 32'hCAFE_F00D) begin errors++;
            $display("FAIL rw_readback got %h want cafef00d", bus.read_value_out); end
        bus_end();
        bus_start(1'b1, 1'b1, 3'd6, 4'hF, 32'hFFFF_FFFF);
        checks++; if (bus.ready_out !== 1'b1 || bus.read_value_out !== 32'd0) begin errors++;
            $display("FAIL reserved got rdy=%b rd=%h want 1/0", bus.ready_out, bus.read_value_out); end
        bus_end();
        checks++; if (bus.ready_out !== 1'b0) begin errors++;
            $display("FAIL reserved_one_cycle got %b want 0", bus.ready_out); end
    endtask

    task automatic test_msip();
        bus_start(1'b0, 1'b1, 3'd4, 4'b0001, 32'd1);
        checks++; if (sirq !== MSIP_EN) begin errors++;
            $display("FAIL msip_set got %b want %b", sirq, MSIP_EN); end
        bus_end();
        bus_start(1'b1, 1'b0, 3'd4, 4'h0, 32'd0);
        checks++; if (bus.read_value_out !== {31'b0, MSIP_EN}) begin errors++;
            $display("FAIL msip_read got %h want %h", bus.read_value_out, {31'b0, MSIP_EN}); end
        bus_end();
        bus_start(1'b0, 1'b1, 3'd4, 4'b1110, 32'd0);
        bus_end();
        checks++; if (sirq !== MSIP_EN) begin errors++;
            $display("FAIL msip_lane got %b want %b", sirq, MSIP_EN); end
        bus_start(1'b0, 1'b1, 3'd4, 4'b0001, 32'hFFFF_FFFE);
        checks++; if (sirq !== 1'b0) begin errors++;
            $display("FAIL msip_clear got %b want 0", sirq); end
        bus_end();
    endtask

    task automatic test_hold();
        bus.sel_in = 1'b1;
        bus.read_in = 1'b1;
        bus.write_in = 1'b0;
        bus.address_in = 32'h0000_0008;
        step();
        checks++; if (bus.ready_out !== 1'b1) begin errors++;
            $display("FAIL hold_first got %b want 1", bus.ready_out); end
        step();
        checks++; if (bus.ready_out !== 1'b0) begin errors++;
            $display("FAIL hold_gap got %b want 0", bus.ready_out); end
        step();
        checks++; if (bus.ready_out !== 1'b1 || bus.read_value_out !== m_rd) begin errors++;
            $display("FAIL hold_second got rdy=%b rd=%h want 1/%h", bus.ready_out,
                     bus.read_value_out, m_rd); end
        bus_end();
    endtask

    task automatic test_random();
        bit rd, wr;
        for (int t = 0; t < 60; t++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_start(rd, wr, 3'($urandom_range(0, 7)), 4'($urandom()),
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom());
            checks++; if (bus.ready_out !== 1'b1 || (rd && bus.read_value_out !== m_rd)) begin
                errors++;
                $display("FAIL rand_ack %0d got rdy=%b rd=%h want 1/%h", t, bus.ready_out,
                         bus.read_value_out, m_rd); end
            checks++; if (time_out !== m_time || irq !== m_irq || sirq !== m_msip) begin
                errors++;
                $display("FAIL rand_state %0d got %h/%b/%b want %h/%b/%b", t, time_out, irq,
                         sirq, m_time, m_irq, m_msip); end
            bus_end();
            for (int k = $urandom_range(0, 2); k > 0; k--) step();
            checks++; if (bus.ready_out !== 1'b0 || time_out !== m_time || irq !== m_irq) begin
                errors++;
                $display("FAIL rand_idle %0d got %b/%h/%b want 0/%h/%b", t, bus.ready_out,
                         time_out, irq, m_time, m_irq); end
        end
    endtask

    task automatic test_reset_ack();
        bus_start(1'b0, 1'b1, 3'd2, 4'hF, 32'h0000_0055);
        checks++; if (bus.ready_out !== 1'b1) begin errors++;
            $display("FAIL rst_ack_pre got %b want 1", bus.ready_out); end
        reset = 1'b1;
        bus.sel_in = 1'b0;
        bus.write_in = 1'b0;
        step();
        checks++; if (bus.ready_out !== 1'b0 || time_out !== 64'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_ack got rdy=%b t=%h irq=%b want 0/0/0", bus.ready_out,
                     time_out, irq); end
        bus.sel_in = 1'b1;
        bus.write_in = 1'b1;
        bus.write_value_in = 32'h0000_0066;
        step();
        checks++; if (bus.ready_out !== 1'b0) begin errors++;
            $display("FAIL rst_req got %b want 0", bus.ready_out); end
        reset = 1'b0;
        bus_end();
        bus_start(1'b1, 1'b0, 3'd2, 4'h0, 32'd0);
        checks++; if (bus.read_value_out !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL rst_discard got %h want ffffffff", bus.read_value_out); end
        bus_end();
    endtask

    task automatic test_prescale();
        reset4 = 1'b1;
        step();
        reset4 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++; if (time4 !== 64'(k / 4)) begin errors++;
                $display("FAIL prescale cyc %0d got %0d want %0d", k, time4, k / 4); end
        end
        checks++; if (time4 !== 64'd3 || irq4 !== 1'b0 || bus4.ready_out !== 1'b0) begin
            errors++;
            $display("FAIL prescale_end got %0d/%b/%b want 3/0/0", time4, irq4, bus4.ready_out); end
    endtask

    initial begin
        bus.sel_in = 1'b0;  bus.read_in = 1'b0;  bus.write_in = 1'b0;
        bus.address_in = '0; bus.write_mask_in = '0; bus.write_value_in = '0;
        bus4.sel_in = 1'b0; bus4.read_in = 1'b0; bus4.write_in = 1'b0;
        bus4.address_in = '0; bus4.write_mask_in = '0; bus4.write_value_in = '0;
        test_reset();
        test_cmp_irq();
        test_wrap();
        test_byte_mask();
        test_msip();
        test_hold();
        test_random();
        test_reset_ack();
        test_prescale();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
